bubble_sort: RTL and testbench

Register-file sorting accelerator: holds N unsigned words, loaded in parallel by a host, and sorts them in place into ascending order with a sequential bubble sort. One compare-and-swap is performed per clock. Completion is reported by a level `done_o` and a one-cycle `interrupt_o`. It sits as a memory-mapped slave peripheral; the current array contents are always visible on `readdata_o`.

---
 rtl/bubble_sort_pkg.sv | 17 +
 rtl/bubble_sort_cmp_swap.sv | 17 +
 rtl/bubble_sort.sv | 155 +++++++++++++++
 tb/tb_bubble_sort.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bubble_sort_pkg.sv
// Shared types and constants for the bubble_sort register-file sorter.
package bubble_sort_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_N          = 7;

  typedef enum logic {
    IDLE = 1'b0,
    SORT = 1'b1
  } state_e;

  // Width of the pass/index counters; at least one bit even for tiny arrays.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bubble_sort_cmp_swap.sv
// Combinational unsigned compare-and-swap of one adjacent element pair.
module bubble_sort_cmp_swap #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] lo,
  output logic [DATA_WIDTH-1:0] hi,
  output logic                  swap
);

  // Strict compare so equal values stay in place.
  assign swap = (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/bubble_sort.sv
// In-place sequential bubble sort over N registered words, one compare-and-swap per clock.
// Optional macro BUBBLE_SORT_EARLY_EXIT_EN: finish after the first pass with no swap.
module bubble_sort
  import bubble_sort_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int N          = DEFAULT_N
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N-1:0]            load_i,
  input  logic [N*DATA_WIDTH-1:0] writedata_i,
  output logic [N*DATA_WIDTH-1:0] readdata_o,
  input  logic                    start_i,
  input  logic                    abort_i,
  output logic                    done_o,
  output logic                    interrupt_o
);

  localparam int            CW   = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 2);

  typedef logic [DATA_WIDTH-1:0] elem_t;

  elem_t         elem_q [N];
  elem_t         elem_d [N];
  state_e        state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] pass_q, pass_d;
  logic          done_q, done_d;
  logic          irq_q, irq_d;
  logic [CW-1:0] idx_hi;
  elem_t         cmp_lo, cmp_hi;
  logic          cmp_swap;
  logic          sort_finish;

  assign idx_hi = idx_q + CW'(1);

  bubble_sort_cmp_swap #(.DATA_WIDTH(DATA_WIDTH)) u_cmp_swap (
    .a    (elem_q[idx_q]),
    .b    (elem_q[idx_hi]),
    .lo   (cmp_lo),
    .hi   (cmp_hi),
    .swap (cmp_swap)
  );

`ifdef BUBBLE_SORT_EARLY_EXIT_EN
  logic swapped_q, swapped_d;

  // A pass that ends without any swap means the array is already ordered.
  assign sort_finish = (pass_q == LAST) || !(swapped_q || cmp_swap);
`else
  assign sort_finish = (pass_q == LAST);
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    elem_d  = elem_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    done_d  = done_q;
    irq_d   = 1'b0;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    swapped_d = swapped_q;
`endif

    unique case (state_q)
      IDLE: begin
        for (int i = 0; i < N; i++) begin
          if (load_i[i]) elem_d[i] = writedata_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
        if (|load_i) done_d = 1'b0;

        if (abort_i) begin
          done_d = 1'b0;
        end else if (start_i) begin
          state_d = SORT;
          done_d  = 1'b0;
          idx_d   = '0;
          pass_d  = '0;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
          swapped_d = 1'b0;
`endif
        end
      end

      SORT: begin
        if (abort_i) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end else begin
          if (cmp_swap) begin
            elem_d[idx_q]  = cmp_lo;
            elem_d[idx_hi] = cmp_hi;
          end
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
          swapped_d = swapped_q | cmp_swap;
`endif
          if (idx_q == LAST) begin
            idx_d  = '0;
            pass_d = pass_q + CW'(1);
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
            swapped_d = 1'b0;
`endif
            if (sort_finish) begin
              state_d = IDLE;
              pass_d  = '0;
              done_d  = 1'b1;
              irq_d   = 1'b1;
            end
          end else begin
            idx_d = idx_hi;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pass_q  <= '0;
      done_q  <= 1'b0;
      irq_q   <= 1'b0;
      // NOTE: the element array is a small flop bank, not a RAM, so it can and must reset to zero.
      for (int i = 0; i < N; i++) elem_q[i] <= '0;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
      swapped_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      irq_q   <= irq_d;
      elem_q  <= elem_d;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
      swapped_q <= swapped_d;
`endif
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign readdata_o[g*DATA_WIDTH +: DATA_WIDTH] = elem_q[g];
  end

  assign done_o      = done_q;
  assign interrupt_o = irq_q;

endmodule

// File: tb/tb_bubble_sort.sv
// Self-checking bench for bubble_sort: directed cases plus random arrays against a sorting model.
module tb_bubble_sort;

  localparam int DW    = 8;
  localparam int N     = 7;
  localparam int BOUND = 200;

  typedef int unsigned arr_t [N];

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    load = '0;
  logic [N*DW-1:0] writedata = '0;
  logic [N*DW-1:0] readdata;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            done;
  logic            irq;

  int total = 0;
  int bad   = 0;

  bubble_sort #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .writedata_i (writedata),
    .readdata_o  (readdata),
    .start_i     (start),
    .abort_i     (abort),
    .done_o      (done),
    .interrupt_o (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int i);
    return 32'(readdata[i*DW +: DW]);
  endfunction

  function automatic arr_t sorted(input arr_t a);
    arr_t r = a;
    for (int i = 1; i < N; i++) begin
      int unsigned v = r[i];
      int k = i - 1;
      while (k >= 0 && r[k] > v) begin
        r[k+1] = r[k];
        k--;
      end
      r[k+1] = v;
    end
    return r;
  endfunction

  // Contents after a given number of adjacent compare-and-swap steps of the sweep order.
  function automatic arr_t partial(input arr_t a, input int steps);
    arr_t r = a;
    for (int s = 0; s < steps; s++) begin
      int j = s % (N - 1);
      if (r[j] > r[j+1]) begin
        int unsigned t = r[j];
        r[j]   = r[j+1];
        r[j+1] = t;
      end
    end
    return r;
  endfunction

  // Bubble sort needs as many swapping passes as the largest count of bigger elements
  // sitting to the left of any element; early exit adds one clean pass to detect it.
  function automatic int latency(input arr_t a);
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    int kmax = 0;
    int passes;
    for (int i = 0; i < N; i++) begin
      int c = 0;
      for (int j = 0; j < i; j++) if (a[j] > a[i]) c++;
      if (c > kmax) kmax = c;
    end
    passes = (kmax + 1 < N - 1) ? kmax + 1 : N - 1;
    return passes * (N - 1);
`else
    if (a[0] == 0) return (N - 1) * (N - 1);
    return (N - 1) * (N - 1);
`endif
  endfunction

  task automatic check_array(input string tag, input arr_t exp);
    for (int i = 0; i < N; i++) check($sformatf("%s[%0d]", tag, i), rd(i), exp[i]);
  endtask

  // Entered and left at a falling edge.
  task automatic load_all(input arr_t a);
    load = '1;
    for (int i = 0; i < N; i++) writedata[i*DW +: DW] = DW'(a[i]);
    @(posedge clk);
    @(negedge clk);
    load = '0;
  endtask

  task automatic run_sort(input string tag, input arr_t a, input bit inject);
    int cnt = 0;
    bit seen = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    while (cnt < BOUND && !seen) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      seen = irq;
      if (inject && cnt == 3) begin
        load = '1;
        writedata = {N{8'h55}};
        start = 1'b1;
      end else begin
        load = '0;
        start = 1'b0;
      end
    end
    load  = '0;
    start = 1'b0;
    check({tag, "_irq_seen"}, 32'(seen), 1);
    check({tag, "_latency"}, cnt, latency(a));
    check({tag, "_done"}, 32'(done), 1);
    check_array(tag, sorted(a));
    @(posedge clk);
    @(negedge clk);
    check({tag, "_irq_fall"}, 32'(irq), 0);
    check({tag, "_done_sticky"}, 32'(done), 1);
  endtask

  task automatic expect_no_irq(input string tag, input int cycles);
    bit seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (irq) seen = 1'b1;
    end
    check({tag, "_no_irq"}, 32'(seen), 0);
  endtask

  initial begin
    arr_t basic = '{0, 7, 100, 254, 255, 128, 2};
    arr_t dups  = '{9, 9, 3, 3, 255, 0, 0};
    arr_t asc   = '{1, 2, 3, 50, 60, 200, 201};
    arr_t other = '{11, 22, 33, 44, 55, 66, 77};
    arr_t rnd;

    // Reset
    repeat (3) @(negedge clk);
    check_array("reset_held", '{default: 0});
    check("reset_done", 32'(done), 0);
    check("reset_irq", 32'(irq), 0);
    rst = 1'b1;
    @(negedge clk);
    check_array("reset_rel", '{default: 0});
    check("reset_rel_done", 32'(done), 0);

    // Basic sort and done lifetime
    load_all(basic);
    check_array("basic_load", basic);
    run_sort("basic", basic, 1'b0);
    repeat (5) @(negedge clk);
    check("done_hold", 32'(done), 1);
    load_all(basic);
    check("done_clr_load", 32'(done), 0);

    // Abort mid-sort after five compares
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    check("abort_done", 32'(done), 0);
    check("abort_irq", 32'(irq), 0);
    check_array("abort_partial", partial(basic, 5));
    load_all(other);
    check_array("abort_reload", other);
    expect_no_irq("abort", 45);
    check("abort_done_late", 32'(done), 0);

    // Abort beats start in IDLE
    load_all(basic);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    expect_no_irq("abort_start", 45);
    check_array("abort_start_data", basic);
    check("abort_start_done", 32'(done), 0);

    // Loads and start ignored while sorting
    run_sort("inject", basic, 1'b1);

    // Duplicates and mostly descending
    load_all(dups);
    run_sort("dups", dups, 1'b0);

    // Already ascending
    load_all(asc);
    run_sort("asc", asc, 1'b0);

    // Random arrays, some drawn from a tiny range to force duplicates
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++)
        rnd[i] = (t % 2 == 0) ? $urandom_range(255, 0) : $urandom_range(3, 0);
      load_all(rnd);
      run_sort($sformatf("rnd%0d", t), rnd, 1'b0);
    end

    // Reset in the middle of a sort
    load_all(dups);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_array("midreset", '{default: 0});
    check("midreset_done", 32'(done), 0);
    check("midreset_irq", 32'(irq), 0);
    @(negedge clk);
    rst = 1'b1;
    expect_no_irq("midreset", 45);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
